// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver constants (one-hot FSM encodings, frame and mouse packet layout).
package ps2_pkg;
   localparam logic [3:0] ST_IDLE   = 4'b0001;
   localparam logic [3:0] ST_DATA   = 4'b0010;
   localparam logic [3:0] ST_PARITY = 4'b0100;
   localparam logic [3:0] ST_STOP   = 4'b1000;
   localparam int FRAME_BITS      = 11;
   localparam int MOUSE_PKT_BYTES = 3;
   localparam int MOUSE_SYNC_BIT  = 3;
endpackage

// File: rtl/ps2_mouse_rx_if.sv
// ps2_mouse_rx_if: raw PS/2 lines plus decoded byte/packet strobes; slave = receiver, master = its driver.
interface ps2_mouse_rx_if;
   logic        enable;
   logic        PS2C;
   logic        PS2D;
   logic [7:0]  data;
   logic        byte_valid;
   logic        parity_err;
   logic        frame_err;
   logic [23:0] packet;
   logic        packet_valid;
   logic [3:0]  status;
   modport slave (input enable, PS2C, PS2D,
                  output data, byte_valid, parity_err, frame_err, packet, packet_valid, status);
   modport master (output enable, PS2C, PS2D,
                   input data, byte_valid, parity_err, frame_err, packet, packet_valid, status);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser, FILTER_LEN agreement filter and filtered falling-edge pulse.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic qzt_clk,
   input  logic reset,
   input  logic raw_i,
   output logic fall_o
);
   logic [1:0]            sync_q;
   logic [FILTER_LEN-1:0] win_q;
   logic                  level_q, level_d;
   assign level_d = (&win_q) ? 1'b1 : (~|win_q) ? 1'b0 : level_q;
   assign fall_o  = level_q & ~level_d;
   // Preloaded high so an idle bus after reset never looks like an edge.
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         sync_q  <= '1;
         win_q   <= '1;
         level_q <= 1'b1;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         win_q   <= {win_q[FILTER_LEN-2:0], sync_q[1]};
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 device->host frame receiver and 3-byte mouse packet assembler.
// Define PS2_RX_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module ps2_mouse_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
`ifdef PS2_RX_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
   input logic qzt_clk,
   input logic reset,
   ps2_mouse_rx_if.slave bus
);
   logic        fall;
   logic [1:0]  d_sync_q;
   logic        d;
   logic [3:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic        par_ok_q, par_ok_d;
   logic [7:0]  data_q, data_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] pbuf_q, pbuf_d;
   logic [23:0] pkt_q, pkt_d;
   logic        bv_q, bv_d, pv_q, pv_d, pe_q, pe_d, fe_q, fe_d;
`ifdef PS2_RX_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
`endif
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .qzt_clk(qzt_clk), .reset(reset), .raw_i(bus.PS2C), .fall_o(fall)
   );
   assign d = d_sync_q[1];
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      par_ok_d = par_ok_q;
      data_d   = data_q;
      idx_d    = idx_q;
      pbuf_d   = pbuf_q;
      pkt_d    = pkt_q;
      bv_d     = 1'b0;
      pv_d     = 1'b0;
      pe_d     = 1'b0;
      fe_d     = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_d    = (fall || !bus.enable || state_q == ST_IDLE) ? '0 : tmo_q + 32'd1;
`endif
      if (!bus.enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               state_d = d ? ST_IDLE : ST_DATA;
               cnt_d   = '0;
            end
            ST_DATA: begin
               sh_d    = {d, sh_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
               state_d = (cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
            end
            ST_PARITY: begin
               par_ok_d = ^{sh_q, d};
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!d || !par_ok_q) begin
                  fe_d  = !d;
                  pe_d  = d;
                  idx_d = '0;
               end else begin
                  data_d = sh_q;
                  bv_d   = 1'b1;
                  // A packet may only start on a byte carrying the mouse sync bit.
                  if (idx_q != '0 || sh_q[MOUSE_SYNC_BIT]) begin
                     if (idx_q == 2'(MOUSE_PKT_BYTES - 1)) begin
                        pkt_d = {sh_q, pbuf_q};
                        pv_d  = 1'b1;
                        idx_d = '0;
                     end else begin
                        pbuf_d = {sh_q, pbuf_q[15:8]};
                        idx_d  = idx_q + 2'd1;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
`ifdef PS2_RX_TIMEOUT_EN
      end else if (state_q != ST_IDLE && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
         state_d = ST_IDLE;
         fe_d    = 1'b1;
         idx_d   = '0;
`endif
      end
   end
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         d_sync_q <= '1;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         par_ok_q <= 1'b0;
         data_q   <= '0;
         idx_q    <= '0;
         pbuf_q   <= '0;
         pkt_q    <= '0;
         bv_q     <= 1'b0;
         pv_q     <= 1'b0;
         pe_q     <= 1'b0;
         fe_q     <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         d_sync_q <= {d_sync_q[0], bus.PS2D};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         par_ok_q <= par_ok_d;
         data_q   <= data_d;
         idx_q    <= idx_d;
         pbuf_q   <= pbuf_d;
         pkt_q    <= pkt_d;
         bv_q     <= bv_d;
         pv_q     <= pv_d;
         pe_q     <= pe_d;
         fe_q     <= fe_d;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end
   assign bus.data         = data_q;
   assign bus.byte_valid   = bv_q;
   assign bus.parity_err   = pe_q;
   assign bus.frame_err    = fe_q;
   assign bus.packet       = pkt_q;
   assign bus.packet_valid = pv_q;
   assign bus.status       = state_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx: table-driven PS/2 frame vectors plus enable, partial-frame and reset sequences.
module tb_ps2_mouse_rx;
   localparam int H = 24;
   logic qzt_clk = 1'b0;
   logic reset;
   ps2_mouse_rx_if bus();
   ps2_mouse_rx #(
      .FILTER_LEN(8)
`ifdef PS2_RX_TIMEOUT_EN
      , .TIMEOUT_CYCLES(500)
`endif
   ) dut (
      .qzt_clk(qzt_clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 qzt_clk = ~qzt_clk;
   int errors = 0, checks = 0;
   int n_bv = 0, n_pe = 0, n_fe = 0, n_pv = 0, overlap = 0;
   always @(negedge qzt_clk) begin
      if (!reset) begin
         n_bv += int'(bus.byte_valid);
         n_pe += int'(bus.parity_err);
         n_fe += int'(bus.frame_err);
         n_pv += int'(bus.packet_valid);
         if ((int'(bus.byte_valid) + int'(bus.parity_err) + int'(bus.frame_err) > 1) ||
             (bus.packet_valid && !bus.byte_valid))
            overlap++;
      end
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge qzt_clk);
      #1;
   endtask
   task automatic send_bit(input logic b);
      bus.PS2C = 1'b1;
      cyc(H / 2);
      bus.PS2D = b;
      cyc(H / 2);
      bus.PS2C = 1'b0;
      cyc(H);
   endtask
   task automatic send_frame(input logic [7:0] v, input logic p, input logic s, input int nbits);
      logic [10:0] f;
      f = {s, p, v, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
      bus.PS2C = 1'b1;
      cyc(H / 2);
      bus.PS2D = 1'b1;
      cyc(H / 2 + 8);
   endtask
   typedef struct {
      logic [7:0]  b;
      logic        p;
      logic        s;
      logic        glitch;
      int          bv, pe, fe, pv;
      logic [7:0]  data;
      logic [23:0] pkt;
   } vec_t;
   vec_t v[11];
   int b0, p0, f0, q0;
   initial begin
      v[0]  = '{8'hFA, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 8'hFA, 24'h000000};
      v[1]  = '{8'h55, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 8'hFA, 24'h000000};
      v[2]  = '{8'h08, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'h08, 24'h000000};
      v[3]  = '{8'h05, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 8'h05, 24'h000000};
      v[4]  = '{8'hFB, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 8'hFB, 24'hFB0508};
      v[5]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 8'h00, 24'hFB0508};
      v[6]  = '{8'h09, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 8'h09, 24'hFB0508};
      v[7]  = '{8'h01, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'h01, 24'hFB0508};
      v[8]  = '{8'h02, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 8'h02, 24'h020109};
      v[9]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 1, 0, 0, 0, 8'h3C, 24'h020109};
      v[10] = '{8'h12, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 8'h3C, 24'h020109};
      bus.enable = 1'b1;
      bus.PS2C   = 1'b1;
      bus.PS2D   = 1'b1;
      reset      = 1'b1;
      cyc(4);
      reset = 1'b0;
      cyc(2);
      check("reset data", 32'(bus.data), 32'h00);
      check("reset packet", 32'(bus.packet), 32'h0);
      check("reset status", 32'(bus.status), 32'h1);
      check("reset strobes", 32'({bus.byte_valid, bus.parity_err, bus.frame_err, bus.packet_valid}), 32'h0);
      for (int i = 0; i < 11; i++) begin
         b0 = n_bv; p0 = n_pe; f0 = n_fe; q0 = n_pv;
         if (v[i].glitch) begin
            bus.PS2C = 1'b0;
            cyc(4);
            bus.PS2C = 1'b1;
            cyc(20);
            check($sformatf("v%0d glitch status", i), 32'(bus.status), 32'h1);
         end
         send_frame(v[i].b, v[i].p, v[i].s, 11);
         check($sformatf("v%0d byte_valid", i), 32'(n_bv - b0), 32'(v[i].bv));
         check($sformatf("v%0d parity_err", i), 32'(n_pe - p0), 32'(v[i].pe));
         check($sformatf("v%0d frame_err", i), 32'(n_fe - f0), 32'(v[i].fe));
         check($sformatf("v%0d packet_valid", i), 32'(n_pv - q0), 32'(v[i].pv));
         check($sformatf("v%0d data", i), 32'(bus.data), 32'(v[i].data));
         check($sformatf("v%0d packet", i), 32'(bus.packet), 32'(v[i].pkt));
         check($sformatf("v%0d status", i), 32'(bus.status), 32'h1);
      end
      // enable low mid-frame must discard both the frame and the pending packet byte
      send_frame(8'h08, 1'b0, 1'b1, 11);
      send_frame(8'h77, 1'b0, 1'b0, 4);
      check("partial status", 32'(bus.status), 32'h2);
      b0 = n_bv; p0 = n_pe; f0 = n_fe; q0 = n_pv;
      bus.enable = 1'b0;
      cyc(5);
      check("disable status", 32'(bus.status), 32'h1);
      check("disable strobes", 32'((n_bv - b0) + (n_pe - p0) + (n_fe - f0)), 32'h0);
      bus.enable = 1'b1;
      cyc(2);
      send_frame(8'h0A, 1'b1, 1'b1, 11);
      send_frame(8'h03, 1'b1, 1'b1, 11);
      send_frame(8'h04, 1'b0, 1'b1, 11);
      check("enable pkt count", 32'(n_pv - q0), 32'h1);
      check("enable packet", 32'(bus.packet), 32'h04030A);
      // start + 5 data bits, then idle lines
      f0 = n_fe;
      send_frame(8'h15, 1'b0, 1'b0, 6);
      check("stall status", 32'(bus.status), 32'h2);
`ifdef PS2_RX_TIMEOUT_EN
      for (int i = 0; i < 2000 && n_fe == f0; i++) cyc(1);
      check("timeout frame_err", 32'(n_fe - f0), 32'h1);
      check("timeout status", 32'(bus.status), 32'h1);
`else
      cyc(300);
      check("stall frame_err", 32'(n_fe - f0), 32'h0);
      check("stall status held", 32'(bus.status), 32'h2);
`endif
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      check("post-reset data", 32'(bus.data), 32'h00);
      check("post-reset packet", 32'(bus.packet), 32'h0);
      check("post-reset status", 32'(bus.status), 32'h1);
      check("post-reset strobes", 32'({bus.byte_valid, bus.parity_err, bus.frame_err, bus.packet_valid}), 32'h0);
      check("strobe overlap", 32'(overlap), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
